basic6_pair_source: RTL
=======================

BASIC6_PAIR_SOURCE -- requirements
Module: basic6_pair_source

Interface
REQ-001 SHALL have parameter START_VAL, default 4, first value driven on b_out after reset.
REQ-002 SHALL have parameter STEP, default 1, increment applied to the b_out value after each completed pair.
REQ-003 SHALL have parameter GAP, default 0, minimum idle cycles between the B transfer and the next A offer (0..255).
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1, permits starting a new pair from IDLE.
REQ-007 SHALL have port b_out, output, 32 signed, data word for consumer port 1.
REQ-008 SHALL have port b_out_sync, input, 1, consumer ready on port 1.
REQ-009 SHALL have port b_out_notify, output, 1, data valid on port 1.
REQ-010 SHALL have port b_out2, output, 32 signed, data word for consumer port 2.
REQ-011 SHALL have port b_out2_sync, input, 1, consumer ready on port 2.
REQ-012 SHALL have port b_out2_notify, output, 1, data valid on port 2.
REQ-013 SHALL have port pairs_sent, output, 16, count of completed A+B pairs.

Function
REQ-014 SHALL implement states SEND_A, SEND_B, IDLE; all outputs registered.
REQ-015 SHALL complete a port-N transfer on a rising edge where its notify=1 and its sync=1.
REQ-016 SHALL hold b_out/b_out2 stable while the corresponding notify=1 and no transfer has completed.
REQ-017 SHALL ignore sync while the corresponding notify=0; no state change.
REQ-018 SHALL in SEND_A drive b_out_notify=1, b_out=val, b_out2_notify=0.
REQ-019 SHALL on port-1 transfer: sum <= sum+val, b_out2 <= sum+val, b_out_notify <= 0, b_out2_notify <= 1, state <= SEND_B; same edge.
REQ-020 SHALL in SEND_B keep b_out2_notify=1 until port-2 transfer; b_out_notify=0.
REQ-021 SHALL on port-2 transfer: val <= val+STEP, pairs_sent <= pairs_sent+1, b_out2_notify <= 0.
REQ-022 SHALL on port-2 transfer with GAP=0 and en=1 go directly to SEND_A with b_out_notify <= 1, b_out <= val+STEP; otherwise go to IDLE, gap counter <= 0.
REQ-023 SHALL in IDLE hold both notifies 0, increment gap counter each cycle saturating at GAP.
REQ-024 SHALL leave IDLE for SEND_A when gap counter >= GAP and en=1, asserting b_out_notify and b_out=val on that edge.
REQ-025 SHALL treat en only in IDLE and at the REQ-022 decision; en=0 in SEND_A/SEND_B does not abort an offer.
REQ-026 SHALL compute val, sum modulo 2^32 (two's-complement wrap) and pairs_sent modulo 2^16.
REQ-027 SHALL, with both syncs held high continuously, GAP=0, en=1, sustain one transfer per cycle alternating A, B.

Reset
REQ-028 SHALL on rst: state=SEND_A, val=START_VAL, sum=0, b_out=START_VAL, b_out_notify=1, b_out2=0, b_out2_notify=0, pairs_sent=0, gap counter=0.
REQ-029 SHALL on rst mid-offer abandon the pending transfer; no partial sum or count update survives.
REQ-030 SHALL first offer after reset release be b_out=START_VAL with b_out_notify=1 without requiring en.

Verification
REQ-031 SHALL cover: defaults, en=1, both syncs high -> b_out 4,5,6 and b_out2 4,9,15; pairs_sent 3 after 6 transfers.
REQ-032 SHALL cover: b_out_sync low 5 cycles with notify=1 -> b_out stays 4, b_out2_notify stays 0; sync high -> transfer next edge.
REQ-033 SHALL cover: GAP=3, syncs high -> exactly 3 IDLE cycles with both notifies 0 between B transfer and next A offer.
REQ-034 SHALL cover: en=0 after first pair -> held in IDLE, no notify, indefinitely; en=1 -> b_out=5 offered next edge.
REQ-035 SHALL cover: START_VAL=32'h7FFFFFFF, STEP=1 -> second b_out = 32'h80000000 (wrap), b_out2 wraps accordingly.
REQ-036 SHALL cover: rst asserted in SEND_B -> outputs return to REQ-028 values asynchronously; next pair b_out=4, b_out2=4.

Source files
------------

// File: rtl/basic6_pair_source.sv
// Two-port paired word source: offers val on port 1, then the running sum on
// port 2, with an optional idle gap between pairs gated by en.
module basic6_pair_source #(
  parameter logic signed [31:0] START_VAL = 32'sd4,
  parameter logic signed [31:0] STEP      = 32'sd1,
  parameter int unsigned        GAP       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic signed [31:0] b_out,
  input  logic               b_out_sync,
  output logic               b_out_notify,
  output logic signed [31:0] b_out2,
  input  logic               b_out2_sync,
  output logic               b_out2_notify,
  output logic [15:0]        pairs_sent
);

  typedef enum logic [1:0] {
    SEND_A,
    SEND_B,
    IDLE
  } state_e;

  localparam logic [8:0] GAP_W  = 9'(GAP);
  localparam logic       NO_GAP = (GAP == 0);

  state_e             state_q;
  logic signed [31:0] val_q, val_d;
  logic signed [31:0] sum_q, sum_d;
  logic signed [31:0] b_out_q;
  logic signed [31:0] b_out2_q;
  logic               b_out_notify_q;
  logic               b_out2_notify_q;
  logic [15:0]        pairs_q, pairs_d;
  logic [7:0]         gap_q, gap_d;
  logic [8:0]         gap_inc;
  logic               idle_done;

  // idle_done counts the current IDLE cycle, so GAP=N yields exactly N idle cycles
  always_comb begin
    val_d     = val_q + STEP;
    sum_d     = sum_q + val_q;
    pairs_d   = pairs_q + 16'd1;
    gap_inc   = {1'b0, gap_q} + 9'd1;
    gap_d     = ({1'b0, gap_q} < GAP_W) ? gap_inc[7:0] : gap_q;
    idle_done = (gap_inc >= GAP_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= SEND_A;
      val_q           <= START_VAL;
      sum_q           <= '0;
      b_out_q         <= START_VAL;
      b_out_notify_q  <= 1'b1;
      b_out2_q        <= '0;
      b_out2_notify_q <= 1'b0;
      pairs_q         <= '0;
      gap_q           <= '0;
    end else begin
      case (state_q)
        SEND_A: begin
          if (b_out_sync) begin
            sum_q           <= sum_d;
            b_out2_q        <= sum_d;
            b_out_notify_q  <= 1'b0;
            b_out2_notify_q <= 1'b1;
            state_q         <= SEND_B;
          end
        end
        SEND_B: begin
          if (b_out2_sync) begin
            val_q           <= val_d;
            pairs_q         <= pairs_d;
            b_out2_notify_q <= 1'b0;
            if (NO_GAP && en) begin
              state_q        <= SEND_A;
              b_out_notify_q <= 1'b1;
              b_out_q        <= val_d;
            end else begin
              state_q <= IDLE;
              gap_q   <= '0;
            end
          end
        end
        IDLE: begin
          gap_q <= gap_d;
          if (idle_done && en) begin
            state_q        <= SEND_A;
            b_out_notify_q <= 1'b1;
            b_out_q        <= val_q;
          end
        end
        default: begin
          state_q         <= SEND_A;
          b_out_notify_q  <= 1'b1;
          b_out2_notify_q <= 1'b0;
          b_out_q         <= val_q;
        end
      endcase
    end
  end

  assign b_out         = b_out_q;
  assign b_out_notify  = b_out_notify_q;
  assign b_out2        = b_out2_q;
  assign b_out2_notify = b_out2_notify_q;
  assign pairs_sent    = pairs_q;

endmodule
